// File: rtl/pool_max2.sv
// Streaming 2x2 max-pool: consumes a raster stream and emits one pooled sample per 2x2 window.
// Build option: define POOL_RELU_EN to clamp negative pooled results to zero (fused ReLU).
module pool_max2 #(
  parameter int IN_DIM = 28,
  parameter int PP     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [PP:0] pxl_in,
  input  logic              in_valid,
  output logic signed [PP:0] pool_out,
  output logic              out_valid,
  output logic              frame_end
);

  localparam int CW   = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
  localparam int HALF = IN_DIM / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic        [CW-1:0] r_col;
  logic        [CW-1:0] r_row;
  logic signed [PP:0]   r_h;
  logic signed [PP:0]   r_linebuf [HALF];
  logic signed [PP:0]   r_pool_out;
  logic                 r_out_valid;
  logic                 r_frame_end;

  logic                 w_col_last;
  logic                 w_row_last;
  logic        [AW-1:0] w_lb_idx;
  logic signed [PP:0]   w_lb_rd;
  logic signed [PP:0]   w_pair;
  logic signed [PP:0]   w_max;
  logic signed [PP:0]   w_result;

  assign w_col_last = (r_col == CW'(IN_DIM - 1));
  assign w_row_last = (r_row == CW'(IN_DIM - 1));
  assign w_lb_idx   = AW'(r_col >> 1);
  assign w_lb_rd    = r_linebuf[w_lb_idx];

  // Both operands are declared signed, so these compares are two's-complement.
  assign w_pair = (r_h > pxl_in) ? r_h : pxl_in;
  assign w_max  = (w_lb_rd > w_pair) ? w_lb_rd : w_pair;

`ifdef POOL_RELU_EN
  assign w_result = (w_max < 0) ? '0 : w_max;
`else
  assign w_result = w_max;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_h         <= '0;
      r_pool_out  <= '0;
      r_out_valid <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_frame_end <= 1'b0;
      if (in_valid) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end

        if (!r_col[0]) begin
          r_h <= pxl_in;
        end else if (r_row[0]) begin
          r_pool_out  <= w_result;
          r_out_valid <= 1'b1;
          r_frame_end <= w_row_last && w_col_last;
        end
      end
    end
  end

  // NOTE: the line buffer has no reset; each entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (in_valid && r_col[0] && !r_row[0]) begin
      r_linebuf[w_lb_idx] <= w_pair;
    end
  end

  assign pool_out  = r_pool_out;
  assign out_valid = r_out_valid;
  assign frame_end = r_frame_end;

endmodule

// File: tb/tb_pool_max2.sv
// Self-checking bench for pool_max2 (IN_DIM=4): directed and randomized frames
// compared against a whole-frame 2x2 max reference model.
module tb_pool_max2;

  localparam int IN_DIM = 4;
  localparam int PP     = 8;
  localparam int N      = IN_DIM * IN_DIM;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [PP:0] pxl_in;
  logic              in_valid;
  logic signed [PP:0] pool_out;
  logic              out_valid;
  logic              frame_end;

  pool_max2 #(.IN_DIM(IN_DIM), .PP(PP)) dut (
    .clk      (clk),
    .reset    (reset),
    .pxl_in   (pxl_in),
    .in_valid (in_valid),
    .pool_out (pool_out),
    .out_valid(out_valid),
    .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: position within frame and the frame's pixels so far.
  int               pos = 0;
  int               frame_px [N];
  logic             exp_v;
  logic             exp_fe;
  logic signed [PP:0] exp_pool;

  int got_q[$];
  int fe_cnt;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int window_max(int r, int c);
    int m;
    int v;
    m = frame_px[(r-1)*IN_DIM + (c-1)];
    v = frame_px[(r-1)*IN_DIM + c];     if (v > m) m = v;
    v = frame_px[r*IN_DIM + (c-1)];     if (v > m) m = v;
    v = frame_px[r*IN_DIM + c];         if (v > m) m = v;
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic check_outputs();
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    check("frame_end", {31'b0, frame_end}, {31'b0, exp_fe});
    check("pool_out", pool_out, exp_pool);
    if (out_valid === 1'b1) got_q.push_back(int'(pool_out));
    if (frame_end === 1'b1) fe_cnt++;
  endtask

  // Drive one cycle's inputs, predict the registered outputs, then check them at the next negedge.
  task automatic cycle(input logic v, input int px);
    int r;
    int c;
    in_valid = v;
    pxl_in   = (PP+1)'(px);
    exp_v    = 1'b0;
    exp_fe   = 1'b0;
    if (v) begin
      frame_px[pos] = int'(pxl_in);
      r = pos / IN_DIM;
      c = pos % IN_DIM;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_v    = 1'b1;
        exp_pool = (PP+1)'(window_max(r, c));
        exp_fe   = (pos == N - 1);
      end
      pos = (pos + 1) % N;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b0;
    in_valid = 1'b1;
    pos      = 0;
    exp_v    = 1'b0;
    exp_fe   = 1'b0;
    exp_pool = '0;
    repeat (n) begin
      pxl_in = (PP+1)'($urandom_range(0, 511));
      @(negedge clk);
      check_outputs();
    end
    reset    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic check_got(input string tag, input int exp_vals[$], input int exp_fe_cnt);
    check({tag, "_count"}, got_q.size(), exp_vals.size());
    for (int i = 0; i < exp_vals.size() && i < got_q.size(); i++)
      check(tag, got_q[i], exp_vals[i]);
    check({tag, "_frame_end_count"}, fe_cnt, exp_fe_cnt);
    got_q.delete();
    fe_cnt = 0;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    pxl_in   = '0;
    fe_cnt   = 0;
    @(negedge clk);

    // Reset held with in_valid high: outputs stay at reset values.
    do_reset(3);
    got_q.delete();
    fe_cnt = 0;

    // Ramp frame, continuous input.
    for (int i = 0; i < N; i++) cycle(1'b1, i);
    cycle(1'b0, 0);
    check_got("ramp", '{5, 7, 13, 15}, 1);

    // Negative samples; one -3 in row 2 col 1.
    for (int i = 0; i < N; i++) cycle(1'b1, (i == 2*IN_DIM + 1) ? -3 : -100);
    cycle(1'b0, 0);
`ifdef POOL_RELU_EN
    check_got("neg", '{0, 0, 0, 0}, 1);
`else
    check_got("neg", '{-100, -100, -3, -100}, 1);
`endif

    // Ramp with random in_valid gaps of 0-3 cycles.
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cycle(1'b0, $urandom_range(0, 511));
      cycle(1'b1, i);
    end
    cycle(1'b0, 0);
    check_got("gap", '{5, 7, 13, 15}, 1);

    // Reset mid-frame after 6 samples, then a full ramp frame.
    for (int i = 0; i < 6; i++) cycle(1'b1, i);
    got_q.delete();
    fe_cnt = 0;
    do_reset(1);
    for (int i = 0; i < N; i++) cycle(1'b1, i);
    cycle(1'b0, 0);
    check_got("midreset", '{5, 7, 13, 15}, 1);

    // Back-to-back frames, second offset by +16.
    for (int i = 0; i < 2*N; i++) cycle(1'b1, i);
    cycle(1'b0, 0);
    check_got("b2b", '{5, 7, 13, 15, 21, 23, 29, 31}, 2);

    // Randomized signed frames with random gaps, checked cycle by cycle against the model.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) cycle(1'b0, $urandom_range(0, 511));
        cycle(1'b1, $urandom_range(0, 511));
      end
    end
    cycle(1'b0, 0);
    check("rand_frame_end_count", fe_cnt, 4);
    check("rand_pulse_count", got_q.size(), 4 * (IN_DIM/2) * (IN_DIM/2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pool_max2.md
# pool_max2

Streaming 2x2 max-pool stage: the consumer side of the convolution output stream. It accepts the raster-ordered `conv_out`/`valid` samples produced by a conv stage. It emits one pooled sample per non-overlapping 2x2 window, in raster order, with a one-cycle valid pulse. It sits between a conv stage and the next conv stage or the classifier, halving each spatial dimension (LeNet-style 28x28 -> 14x14).

## Interface
- `IN_DIM`, 28, valid input samples per row and rows per frame; must be even and >= 2
- `PP`, 8, pixel precision MSB index; samples are `PP+1` bits signed
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (reset asserted when 0)
- `pxl_in`  in  PP+1  signed input sample (conv output)
- `in_valid`  in  1  `pxl_in` is a valid sample this cycle
- `pool_out`  out  PP+1  signed pooled sample
- `out_valid`  out  1  one-cycle pulse; `pool_out` is valid this cycle
- `frame_end`  out  1  one-cycle pulse coincident with the last `out_valid` of a frame

## Operation
- Input is a raster stream of `IN_DIM*IN_DIM` valid samples per frame; `in_valid` may deassert arbitrarily between samples. Cycles with `in_valid=0` change no state except clearing the output pulses.
- Counters `col`, `row` in 0..IN_DIM-1 track the position of the next valid sample. They advance only on `in_valid`. `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last sample, and the next sample is (0,0) of a new frame.
- Even `col`: the sample is stored in holding register `h`.
- Odd `col`: `pair = max(h, pxl_in)` as a signed compare.
  - Even `row`: `pair` is written into line buffer entry `col>>1`. The buffer has `IN_DIM/2` entries of `PP+1` bits.
  - Odd `row`: `result = max(linebuf[col>>1], pair)` is registered to `pool_out`, and `out_valid` is pulsed.
- `frame_end` pulses together with `out_valid` when the triggering sample was at (IN_DIM-1, IN_DIM-1).
- Outputs per frame: `(IN_DIM/2)^2`. There is no back-pressure; the downstream stage must accept every pulse.
- Ties: equal values give that value. There is no saturation; widths are unchanged end to end.

## Timing
- Reset values: `pool_out=0`, `out_valid=0`, `frame_end=0`, `row=0`, `col=0`, `h=0`. Line buffer contents are not reset; every entry is written before it is read.
- Latency: `out_valid` rises on the clock edge after the edge that samples the odd-row/odd-col input, so the latency is 1 cycle.
- `pool_out` holds its last value until the next `out_valid`. `out_valid` and `frame_end` are high for exactly one cycle.
- Maximum throughput: one input per cycle. Continuous input yields a pulse every 2 cycles during odd rows and none during even rows.
- Reset mid-frame: all counters and outputs return to their reset values immediately. The first valid sample after release is treated as (0,0). Partial-frame data is discarded.
- Frame boundary: the last sample of frame N and the first sample of frame N+1 may arrive on consecutive cycles, with no bubble required.

## Configuration
- `POOL_RELU_EN` defined: the registered result is `(result < 0) ? 0 : result`, which fuses ReLU into the pool stage.
- `POOL_RELU_EN` not defined: `result` passes unmodified, and negative values propagate.

## Test plan
- Reset: hold `reset=0` for 3 cycles with `in_valid=1` -> `pool_out=0`, `out_valid=0`, `frame_end=0` throughout.
- Ramp (IN_DIM=4): continuous `in_valid`, `pxl_in` = 0..15 raster -> exactly 4 pulses with `pool_out` = 5, 7, 13, 15. Each pulse occurs 1 cycle after the inputs 5, 7, 13, 15 respectively. `frame_end` fires only with 15.
- Negatives (IN_DIM=4): all samples -100 except row 2 col 1 = -3 -> outputs -100, -100, -3, -100. With `POOL_RELU_EN`: outputs 0, 0, 0, 0.
- Gapped input: ramp stream with random 0-3 cycle `in_valid` gaps -> same 4 values in order. No pulse occurs during gap cycles except the 1-cycle-latency pulse.
- Reset mid-frame: 6 ramp samples, pulse `reset=0` for 1 cycle, then a full ramp frame -> exactly 4 outputs 5, 7, 13, 15.
- Back-to-back frames: two ramp frames, the second offset by +16, with no gap -> outputs 5, 7, 13, 15, 21, 23, 29, 31. `frame_end` fires with 15 and with 31.
